systolic_mac_pe: RTL

//  Parametrised systolic-array processing element: forwards A (west->east) and B (north->south) operands with valid

---
 rtl/systolic_mac_pe_if.sv | 35 +++
 rtl/systolic_mac_pe.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_mac_pe_if.sv
// Operand, control and result bundle of one systolic MAC PE.
interface systolic_mac_pe_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] a_in;
  logic              a_valid_in;
  logic [DATA_W-1:0] b_in;
  logic              b_valid_in;
  logic              start;
  logic [CNT_W-1:0]  k_len;
  logic [DATA_W-1:0] a_out;
  logic              a_valid_out;
  logic [DATA_W-1:0] b_out;
  logic              b_valid_out;
  logic [ACC_W-1:0]  p_out;
  logic              p_valid;
  logic              busy;
  logic              overflow;

  modport master (
    output a_in, a_valid_in, b_in, b_valid_in,
    output start, k_len,
    input  a_out, a_valid_out, b_out, b_valid_out,
    input  p_out, p_valid, busy, overflow
  );

  modport slave (
    input  a_in, a_valid_in, b_in, b_valid_in,
    input  start, k_len,
    output a_out, a_valid_out, b_out, b_valid_out,
    output p_out, p_valid, busy, overflow
  );
endinterface

// File: rtl/systolic_mac_pe.sv
// Systolic PE: forwards A/B operands, accumulates a k_len-long
// dot product through a pipelined multiplier, pulses the result.
module systolic_mac_pe #(
  parameter int DATA_W     = 32,
  parameter int ACC_W      = 64,
  parameter int CNT_W      = 16,
  parameter int MUL_STAGES = 1,
  parameter int SIGNED     = 0,
  parameter int SATURATE   = 1
) (
  input  logic             clk,
  input  logic             rst,
  systolic_mac_pe_if.slave pe
);
  localparam int PW = 2 * DATA_W;
  localparam int SW = ACC_W + 1;
  localparam int FW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
  localparam logic [FW-1:0] FL_LAST = FW'(MUL_STAGES - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FW-1:0]     fl_q, fl_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  p_q, p_d;
  logic              ovf_q, ovf_d;
  logic              pv_q, pv_d;
  logic [DATA_W-1:0] a_q, b_q;
  logic              av_q, bv_q;
  logic [PW-1:0]     prod_q [MUL_STAGES];
  logic [MUL_STAGES-1:0] pvld_q;

  logic              fire;
  logic [PW-1:0]     a_x, b_x, mul_w, last_p;
  logic [SW-1:0]     acc_x, ext_x, sum_w;
  logic [ACC_W-1:0]  sat_w;
  logic              ovf_w;

  assign fire = pe.a_valid_in & pe.b_valid_in
              & (state_q == ACCUM) & (cnt_q < k_q);

  // Low PW bits of the extended product equal the exact product.
  always_comb begin
    a_x = {{DATA_W{1'b0}}, pe.a_in};
    b_x = {{DATA_W{1'b0}}, pe.b_in};
    if (SIGNED != 0) begin
      a_x = {{DATA_W{pe.a_in[DATA_W-1]}}, pe.a_in};
      b_x = {{DATA_W{pe.b_in[DATA_W-1]}}, pe.b_in};
    end
    mul_w = a_x * b_x;
  end

  assign last_p = prod_q[MUL_STAGES-1];

  always_comb begin
    acc_x = {1'b0, acc_q};
    ext_x = {{(SW-PW){1'b0}}, last_p};
    if (SIGNED != 0) begin
      acc_x = {acc_q[ACC_W-1], acc_q};
      ext_x = {{(SW-PW){last_p[PW-1]}}, last_p};
    end
    sum_w = acc_x + ext_x;
    if (SIGNED != 0) begin
      ovf_w = sum_w[ACC_W] ^ sum_w[ACC_W-1];
      sat_w = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                           : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      ovf_w = sum_w[ACC_W];
      sat_w = '1;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    fl_d    = fl_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    p_d     = p_q;
    pv_d    = 1'b0;
    if (pvld_q[MUL_STAGES-1]) begin
      acc_d = (ovf_w && SATURATE != 0) ? sat_w : sum_w[ACC_W-1:0];
      ovf_d = ovf_q | ovf_w;
    end
    unique case (state_q)
      IDLE: ;
      ACCUM: begin
        if (fire) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == k_q) begin
            state_d = FLUSH;
            fl_d    = '0;
          end
        end
      end
      FLUSH: begin
        if (fl_q == FL_LAST) state_d = DONE;
        else fl_d = fl_q + FW'(1);
      end
      DONE: begin
        p_d     = acc_q;
        pv_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A start always wins: any tile in progress is dropped silently.
    if (pe.start) begin
      k_d     = pe.k_len;
      cnt_d   = '0;
      fl_d    = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
      p_d     = p_q;
      pv_d    = 1'b0;
      state_d = (pe.k_len == '0) ? DONE : ACCUM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      fl_q    <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      p_q     <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      fl_q    <= fl_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      p_q     <= p_d;
      pv_q    <= pv_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pvld_q <= '0;
      for (int i = 0; i < MUL_STAGES; i++) prod_q[i] <= '0;
    end else begin
      prod_q[0] <= mul_w;
      pvld_q[0] <= fire & ~pe.start;
      for (int i = 1; i < MUL_STAGES; i++) begin
        prod_q[i] <= prod_q[i-1];
        pvld_q[i] <= pvld_q[i-1] & ~pe.start;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      av_q <= 1'b0;
      bv_q <= 1'b0;
    end else begin
      a_q  <= pe.a_in;
      b_q  <= pe.b_in;
      av_q <= pe.a_valid_in;
      bv_q <= pe.b_valid_in;
    end
  end

  assign pe.a_out       = a_q;
  assign pe.b_out       = b_q;
  assign pe.a_valid_out = av_q;
  assign pe.b_valid_out = bv_q;
  assign pe.p_out       = p_q;
  assign pe.p_valid     = pv_q;
  assign pe.busy        = (state_q != IDLE);
  assign pe.overflow    = ovf_q;
endmodule
